// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and saturating counter helpers for the branch target predictor
//
// Contents:
//   bp_state_e         - controller state: BP_SWEEP (clearing valid bits) or BP_RUN
//   ctr_word_t         - wide carrier type for counters of any width up to 32 bits
//   ctr_max(w)         - largest value of a w-bit counter
//   ctr_inc(c, w)      - saturating increment of a w-bit counter
//   ctr_dec(c, w)      - saturating decrement of a w-bit counter
//   ctr_weak_taken(w)  - weak-taken encoding: MSB set, all other bits clear

package bp_pkg;

  typedef enum logic {
    BP_SWEEP = 1'b0,
    BP_RUN   = 1'b1
  } bp_state_e;

  localparam int CTR_MAX_W = 32;

  typedef logic [CTR_MAX_W-1:0] ctr_word_t;

  // For w == 32 the shift yields 0 and the subtraction wraps to all ones.
  function automatic ctr_word_t ctr_max(input int w);
    return (ctr_word_t'(1) << w) - ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t ctr_inc(input ctr_word_t c, input int w);
    return (c >= ctr_max(w)) ? c : c + ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t ctr_dec(input ctr_word_t c, input int w);
    return (c == '0) ? c : c - ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t ctr_weak_taken(input int w);
    return ctr_word_t'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/bp_entry_ram.sv
// rtl/bp_entry_ram.sv - predictor entry storage: valid vector plus tag/target/counter arrays
//
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset (valid bits only)
//   lkp_addr_i         - lookup read address; lkp_*_o are its combinational read data
//   upd_addr_i         - update read address; upd_*_o are its combinational read data
//   we_i, waddr_i      - write enable/address; a write sets the valid bit and stores all fields
//   wtag_i, wtarget_i, wctr_i - write data
//   clr_i, clr_addr_i  - clear a single valid bit (start-up sweep)
//
// The update path must know the old tag and counter of the entry it modifies,
// so the lookup port and the update path each have their own asynchronous read.

module bp_entry_ram #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 11,
  parameter int TAG_W = 5,
  parameter int CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] lkp_addr_i,
  output logic             lkp_valid_o,
  output logic [TAG_W-1:0] lkp_tag_o,
  output logic [PC_W-1:0]  lkp_target_o,
  output logic [CTR_W-1:0] lkp_ctr_o,
  input  logic [IDX_W-1:0] upd_addr_i,
  output logic             upd_valid_o,
  output logic [TAG_W-1:0] upd_tag_o,
  output logic [PC_W-1:0]  upd_target_o,
  output logic [CTR_W-1:0] upd_ctr_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [PC_W-1:0]  wtarget_i,
  input  logic [CTR_W-1:0] wctr_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_addr_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];
  logic [CTR_W-1:0] ctr_q    [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q[clr_addr_i] <= 1'b0;
      if (we_i)  valid_q[waddr_i]    <= 1'b1;
    end
  end

  // Payload fields carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[waddr_i]    <= wtag_i;
      target_q[waddr_i] <= wtarget_i;
      ctr_q[waddr_i]    <= wctr_i;
    end
  end

  assign lkp_valid_o  = valid_q[lkp_addr_i];
  assign lkp_tag_o    = tag_q[lkp_addr_i];
  assign lkp_target_o = target_q[lkp_addr_i];
  assign lkp_ctr_o    = ctr_q[lkp_addr_i];

  assign upd_valid_o  = valid_q[upd_addr_i];
  assign upd_tag_o    = tag_q[upd_addr_i];
  assign upd_target_o = target_q[upd_addr_i];
  assign upd_ctr_o    = ctr_q[upd_addr_i];

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - tagged branch target buffer with saturating direction counters
//
// Optional feature: define BP_GSHARE_EN to XOR a global history register into the lookup index.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   lookup_pc         - fetch PC, looked up combinationally
//   pred_hit          - entry valid and tag matches
//   pred_taken        - hit and counter MSB set
//   pred_target       - stored target, 0 on miss
//   pred_idx          - table index used for this lookup
//   upd_valid         - one resolved conditional branch this cycle
//   upd_idx           - pred_idx captured at fetch of that branch
//   upd_pc            - branch PC (tag source)
//   upd_taken         - resolved direction
//   upd_target        - resolved target
//   ready             - 0 while the start-up clearing sweep runs

module branch_target_predictor import bp_pkg::*; #(
  parameter int PC_W   = 16,
  parameter int IDX_W  = 11,
  parameter int TAG_W  = 5,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  output logic             ready
);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [IDX_W-1:0] lkp_idx;
  logic             accept;

  logic             lkp_valid, upd_rd_valid;
  logic [TAG_W-1:0] lkp_tag, upd_rd_tag;
  logic [PC_W-1:0]  lkp_target, upd_rd_target;
  logic [CTR_W-1:0] lkp_ctr, upd_rd_ctr;

  logic             upd_hit;
  logic             we;
  logic [PC_W-1:0]  wtarget;
  logic [CTR_W-1:0] wctr;
  ctr_word_t        ctr_next;

  assign ready  = (state_q == BP_RUN);
  assign accept = upd_valid & ready;

  // Start-up sweep: one valid bit cleared per cycle, RUN after the last index.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (state_q == BP_SWEEP) begin
      if (&sweep_idx_q) begin
        state_d = BP_RUN;
      end else begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BP_SWEEP;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // History only advances on accepted updates, so it is frozen during the sweep.
  always_comb begin
    ghr_d = ghr_q;
    if (accept) ghr_d = (ghr_q << 1) | HIST_W'(upd_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  assign lkp_idx = lookup_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
`else
  assign lkp_idx = lookup_pc[IDX_W-1:0];
`endif

  // Update writes land at upd_idx, so the low PC bits of upd_pc carry no information.
  logic unused_upd_lo;
  assign unused_upd_lo = ^upd_pc[IDX_W-1:0];

  if (IDX_W + TAG_W < PC_W) begin : g_unused_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^{lookup_pc[PC_W-1:IDX_W+TAG_W], upd_pc[PC_W-1:IDX_W+TAG_W]};
  end

  bp_entry_ram #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .CTR_W (CTR_W)
  ) u_ram (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .lkp_addr_i   (lkp_idx),
    .lkp_valid_o  (lkp_valid),
    .lkp_tag_o    (lkp_tag),
    .lkp_target_o (lkp_target),
    .lkp_ctr_o    (lkp_ctr),
    .upd_addr_i   (upd_idx),
    .upd_valid_o  (upd_rd_valid),
    .upd_tag_o    (upd_rd_tag),
    .upd_target_o (upd_rd_target),
    .upd_ctr_o    (upd_rd_ctr),
    .we_i         (we),
    .waddr_i      (upd_idx),
    .wtag_i       (upd_pc[IDX_W+TAG_W-1:IDX_W]),
    .wtarget_i    (wtarget),
    .wctr_i       (wctr),
    .clr_i        (state_q == BP_SWEEP),
    .clr_addr_i   (sweep_idx_q)
  );

  // A not-taken miss has nothing worth allocating, so it writes nothing.
  assign upd_hit = upd_rd_valid & (upd_rd_tag == upd_pc[IDX_W+TAG_W-1:IDX_W]);
  assign we      = accept & (upd_hit | upd_taken);
  assign wtarget = (upd_hit & ~upd_taken) ? upd_rd_target : upd_target;

  always_comb begin
    ctr_next = ctr_weak_taken(CTR_W);
    if (upd_hit) begin
      if (upd_taken) ctr_next = ctr_inc(ctr_word_t'(upd_rd_ctr), CTR_W);
      else           ctr_next = ctr_dec(ctr_word_t'(upd_rd_ctr), CTR_W);
    end
  end

  assign wctr = ctr_next[CTR_W-1:0];

  // Lookup reads the table as it stood at the start of the cycle; no write bypass.
  assign pred_idx    = lkp_idx;
  assign pred_hit    = ready & lkp_valid & (lkp_tag == lookup_pc[IDX_W+TAG_W-1:IDX_W]);
  assign pred_taken  = pred_hit & lkp_ctr[CTR_W-1];
  assign pred_target = pred_hit ? lkp_target : '0;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - self-checking bench for branch_target_predictor

module tb_branch_target_predictor;

  localparam int PC_W   = 16;
  localparam int IDX_W  = 11;
  localparam int TAG_W  = 5;
  localparam int CTR_W  = 2;
  localparam int HIST_W = 8;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int CWEAK  = 1 << (CTR_W - 1);

  logic             clk;
  logic             rst_n;
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             ready;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(
    .PC_W   (PC_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .CTR_W  (CTR_W),
    .HIST_W (HIST_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_idx    (pred_idx),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .ready       (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // Reference model: table of entries in plain ints, history as an int.
  bit m_valid  [DEPTH];
  int m_tag    [DEPTH];
  int m_target [DEPTH];
  int m_ctr    [DEPTH];
  int m_ghr;
  int m_cycles;

  function automatic int m_index(input logic [PC_W-1:0] pc);
`ifdef BP_GSHARE_EN
    return int'(pc[IDX_W-1:0]) ^ m_ghr;
`else
    return int'(pc[IDX_W-1:0]);
`endif
  endfunction

  function automatic int tag_of(input logic [PC_W-1:0] pc);
    return int'(pc[IDX_W+TAG_W-1:IDX_W]);
  endfunction

  function automatic bit m_ready();
    return m_cycles >= DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_ghr    = 0;
    m_cycles = 0;
  endtask

  task automatic model_clock(input logic uv, input logic [IDX_W-1:0] uidx,
                             input logic [PC_W-1:0] upc, input logic ut,
                             input logic [PC_W-1:0] utgt);
    int  i;
    bit  hit;
    i = int'(uidx);
    if (m_ready() && uv) begin
      hit = m_valid[i] && (m_tag[i] == tag_of(upc));
      if (hit) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
          m_target[i] = int'(utgt);
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = int'(utgt);
        m_ctr[i]    = CWEAK;
      end
      m_ghr = ((m_ghr * 2) + (ut ? 1 : 0)) % (1 << HIST_W);
    end
    m_cycles++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_check(input logic [PC_W-1:0] lpc, input logic uv,
                             input logic [IDX_W-1:0] uidx, input logic [PC_W-1:0] upc,
                             input logic ut, input logic [PC_W-1:0] utgt);
    int i;
    bit hit;
    lookup_pc  = lpc;
    upd_valid  = uv;
    upd_idx    = uidx;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    #1;
    i   = m_index(lpc);
    hit = m_ready() && m_valid[i] && (m_tag[i] == tag_of(lpc));
    check("ready", 32'(ready), 32'(m_ready()));
    check("pred_idx", 32'(pred_idx), 32'(i));
    check("pred_hit", 32'(pred_hit), 32'(hit));
    check("pred_taken", 32'(pred_taken), 32'(hit && (m_ctr[i] >= CWEAK)));
    check("pred_target", 32'(pred_target), hit ? 32'(m_target[i]) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock(upd_valid, upd_idx, upd_pc, upd_taken, upd_target);
    #1;
  endtask

  task automatic apply(input logic [PC_W-1:0] lpc, input logic uv,
                       input logic [IDX_W-1:0] uidx, input logic [PC_W-1:0] upc,
                       input logic ut, input logic [PC_W-1:0] utgt);
    drive_check(lpc, uv, uidx, upc, ut, utgt);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_hit", 32'(pred_hit), 32'd0);
    check("reset_taken", 32'(pred_taken), 32'd0);
    check("reset_target", 32'(pred_target), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs the sweep with updates offered every cycle; returns clocks until ready.
  task automatic run_sweep(output int n);
    n = 0;
    while (!ready && n < 3000) begin
      apply(16'($urandom), 1'b1, 11'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      n++;
    end
  endtask

  typedef struct packed {
    logic [PC_W-1:0]  lpc;
    logic             uv;
    logic [IDX_W-1:0] uidx;
    logic [PC_W-1:0]  upc;
    logic             ut;
    logic [PC_W-1:0]  utgt;
    logic             e_hit;
    logic             e_taken;
    logic [PC_W-1:0]  e_tgt;
  } vec_t;

  vec_t tbl [14];
  logic [PC_W-1:0] pool [8];

  initial begin
    int n;
    logic [PC_W-1:0] lpc, upc;
    logic [IDX_W-1:0] uidx;

    tbl[0]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100};
    tbl[2]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100};
    tbl[3]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100};
    tbl[4]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100};
    tbl[5]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100};
    tbl[6]  = '{16'h0040, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100};
    tbl[7]  = '{16'h0840, 1'b1, 11'h040, 16'h0840, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b1, 16'h0200, 1'b1, 1'b0, 16'h0100};
    tbl[9]  = '{16'h0040, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200};
    tbl[10] = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200};
    tbl[11] = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200};
    tbl[12] = '{16'h0040, 1'b1, 11'h040, 16'h0040, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200};
    tbl[13] = '{16'h0040, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200};

    pool[0] = 16'h0040; pool[1] = 16'h0840; pool[2] = 16'h1040; pool[3] = 16'h0123;
    pool[4] = 16'h0923; pool[5] = 16'h07FF; pool[6] = 16'hFFFF; pool[7] = 16'h0000;

    lookup_pc = '0; upd_valid = 1'b0; upd_idx = '0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

    // Start-up sweep with updates offered throughout.
    do_reset();
    run_sweep(n);
    check("sweep_ready_latency", 32'(n), 32'(DEPTH));

    // Directed sequence: allocate, saturation, alias, same-cycle read/write.
`ifndef BP_GSHARE_EN
    for (int k = 0; k < 14; k++) begin
      drive_check(tbl[k].lpc, tbl[k].uv, tbl[k].uidx, tbl[k].upc, tbl[k].ut, tbl[k].utgt);
      check($sformatf("tbl%0d_hit", k), 32'(pred_hit), 32'(tbl[k].e_hit));
      check($sformatf("tbl%0d_taken", k), 32'(pred_taken), 32'(tbl[k].e_taken));
      check($sformatf("tbl%0d_target", k), 32'(pred_target), 32'(tbl[k].e_tgt));
      tick();
    end
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      lpc  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
      upc  = pool[$urandom_range(0, 7)];
      uidx = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'(m_index(upc));
      apply(lpc, 1'($urandom_range(0, 9) < 7), uidx, upc, 1'($urandom_range(0, 2) != 0),
            16'($urandom));
    end

    // Mid-sweep reset: restarts the sweep from index 0.
    do_reset();
    for (int k = 0; k < 100; k++)
      apply(16'($urandom), 1'b1, 11'($urandom), 16'($urandom), 1'b1, 16'($urandom));
    check("midsweep_ready_low", 32'(ready), 32'd0);
    do_reset();
    run_sweep(n);
    check("midsweep_ready_latency", 32'(n), 32'(DEPTH));
    drive_check(16'h0040, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h0000);
    check("after_reset_miss", 32'(pred_hit), 32'd0);
    tick();

    // Two taken updates, then the lookup index reflects the history when gshare is built in.
    apply(16'h0000, 1'b1, 11'(m_index(16'h0040)), 16'h0040, 1'b1, 16'h0100);
    apply(16'h0000, 1'b1, 11'(m_index(16'h0040)), 16'h0040, 1'b1, 16'h0100);
    drive_check(16'h0040, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h0000);
`ifdef BP_GSHARE_EN
    check("gshare_idx", 32'(pred_idx), 32'h043);
`else
    check("plain_idx", 32'(pred_idx), 32'h040);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
